// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the RV32I core: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives memory handshakes and datapath strobes.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             memread,
  input  logic             memwrite,
  input  logic             regwrite,
  input  logic             jal,
  input  logic             jalr,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret,
  output logic             err
);

  // Counter only needs to reach MEM_TIMEOUT-1; the limit check moves us to ERR.
  localparam int            TW       = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam bit            TMO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [TW-1:0] TMO_LAST = TMO_EN ? TW'(MEM_TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              err_q, err_d;
  logic              retire;
  logic              tmo_hit;

  assign tmo_hit = TMO_EN && (tmo_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      tmo_q     <= '0;
      instret_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      instret_q <= instret_d;
      err_q     <= err_d;
    end
  end

  // The timeout counter defaults to zero, so it clears on every state change
  // and only advances while a request is outstanding without a ready.
  always_comb begin
    state_d  = state_q;
    tmo_d    = '0;
    retire   = 1'b0;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = !stall;
        if (!stall) begin
          if (imem_ready) begin
            ir_we   = 1'b1;
            state_d = S_DECODE;
          end else if (tmo_hit) begin
            state_d = S_ERR;
          end else if (TMO_EN) begin
            tmo_d = tmo_q + TW'(1);
          end
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (memread || memwrite) begin
          state_d = S_MEM;
        end else if (regwrite || jal || jalr) begin
          state_d = S_WB;
        end else begin
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = memwrite && !memread;
        if (dmem_ready) begin
          if (memread) begin
            state_d = S_WB;
          end else begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end else if (TMO_EN) begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_ERR: state_d = S_ERR;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    err_d     = (state_d == S_ERR);
    if (jalr) begin
      pc_sel = 2'b10;
    end else if (jal || branch_taken) begin
      pc_sel = 2'b01;
    end else begin
      pc_sel = 2'b00;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;
  assign err     = err_q;

endmodule
